// File: rtl/fade_chaser_n_if.sv
// Control and drive bundle for the fade chaser.
// The master side sets the controls and the slave side produces the LED drive.
interface fade_chaser_n_if #(
  parameter int CHANNELS = 8
);
  localparam int POS_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 enable;
  logic [2:0]           speed;
  logic                 direction;
  logic                 mode;
  logic                 decay_linear;
  logic [CHANNELS-1:0]  led_out;
  logic [POS_WIDTH-1:0] position;
  logic                 step_pulse;

  modport master (
    output enable, speed, direction, mode, decay_linear,
    input  led_out, position, step_pulse
  );

  modport slave (
    input  enable, speed, direction, mode, decay_linear,
    output led_out, position, step_pulse
  );
endinterface

// File: rtl/fade_chaser_n.sv
// N-channel chaser: a full-brightness head steps across the outputs and
// leaves a PWM-faded trail that decays geometrically or linearly.
module fade_chaser_n #(
  parameter int CHANNELS     = 8,
  parameter int LEVEL_BITS   = 5,
  parameter int PWM_BITS     = 11,
  parameter int STEP_WIDTH   = 24,
  parameter int FADE_WIDTH   = 21,
  parameter bit COMMON_ANODE = 1'b1
) (
  input logic           clk,
  input logic           reset,
  fade_chaser_n_if.slave bus
);
  localparam int POS_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [POS_WIDTH-1:0]  POS_LAST  = POS_WIDTH'(CHANNELS - 1);
  localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} bounce_dir_t;

  logic [2:0]            speed_q;
  logic                  direction_q;
  logic                  mode_q;
  logic                  decay_linear_q;
  logic [STEP_WIDTH-1:0] step_cnt;
  logic [STEP_WIDTH-1:0] step_limit;
  logic [FADE_WIDTH-1:0] fade_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [LEVEL_BITS-1:0] slice;
  logic [POS_WIDTH-1:0]  position;
  logic [POS_WIDTH-1:0]  pos_next;
  bounce_dir_t           bounce_dir;
  bounce_dir_t           dir_next;
  logic                  step_pulse;
  logic                  step_now;
  logic [LEVEL_BITS-1:0] level      [CHANNELS];
  logic [LEVEL_BITS-1:0] level_next [CHANNELS];
  logic [CHANNELS-1:0]   lit;

  // >= rather than == so a lowered speed mid-count steps on the next cycle
  assign step_limit = {speed_q, {(STEP_WIDTH-3){1'b1}}};
  assign step_now   = bus.enable && (step_cnt >= step_limit);
  assign slice      = pwm_cnt[PWM_BITS-1 -: LEVEL_BITS];

  always_comb begin
    pos_next = position;
    dir_next = bounce_dir;
    if (CHANNELS > 1) begin
      if (mode_q) begin
        if (bounce_dir == DIR_UP) begin
          if (position == POS_LAST) begin
            dir_next = DIR_DOWN;
            pos_next = position - 1'b1;
          end else begin
            pos_next = position + 1'b1;
          end
        end else begin
          if (position == '0) begin
            dir_next = DIR_UP;
            pos_next = position + 1'b1;
          end else begin
            pos_next = position - 1'b1;
          end
        end
      end else if (direction_q) begin
        pos_next = (position == POS_LAST) ? '0 : position + 1'b1;
      end else begin
        pos_next = (position == '0) ? POS_LAST : position - 1'b1;
      end
    end
  end

  // Head refresh wins over decay, so the head channel never dims
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      level_next[i] = level[i];
      if (position == POS_WIDTH'(i)) begin
        level_next[i] = LEVEL_MAX;
      end else if (fade_cnt == '1) begin
        if (decay_linear_q) begin
          level_next[i] = (level[i] == '0) ? '0 : level[i] - 1'b1;
        end else begin
          level_next[i] = level[i] >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q        <= '0;
      direction_q    <= 1'b0;
      mode_q         <= 1'b0;
      decay_linear_q <= 1'b0;
      step_cnt       <= '0;
      fade_cnt       <= '0;
      pwm_cnt        <= '0;
      position       <= '0;
      bounce_dir     <= DIR_UP;
      step_pulse     <= 1'b0;
      lit            <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) level[i] <= '0;
    end else begin
      speed_q        <= bus.speed;
      direction_q    <= bus.direction;
      mode_q         <= bus.mode;
      decay_linear_q <= bus.decay_linear;
      fade_cnt       <= fade_cnt + 1'b1;
      pwm_cnt        <= pwm_cnt + 1'b1;
      step_pulse     <= step_now;
      if (step_now) begin
        step_cnt   <= '0;
        position   <= pos_next;
        bounce_dir <= dir_next;
      end else if (bus.enable) begin
        step_cnt <= step_cnt + 1'b1;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        level[i] <= level_next[i];
        lit[i]   <= (level[i] != '0) && (level[i] >= slice);
      end
    end
  end

  assign bus.led_out    = lit ^ {CHANNELS{COMMON_ANODE}};
  assign bus.position   = position;
  assign bus.step_pulse = step_pulse;
endmodule

// File: doc/fade_chaser_n.md
Name: fade_chaser_n

Overview:
Parametrised N-channel chaser with PWM-faded trails for LED bars and segment rings on TinyTapeout-class designs. A head position steps across CHANNELS outputs at a selectable rate. The head channel is driven at full brightness, and previously visited channels decay over time, either geometrically or linearly. Supports wrap and bounce modes, an enable input and output polarity selection. It is the generalised successor of the fixed 8-output segment chaser.

Parameters:
CHANNELS, 8, number of LED outputs (>=1)
LEVEL_BITS, 5, brightness level width per channel; max level = 2^LEVEL_BITS-1
PWM_BITS, 11, free-running PWM counter width (>= LEVEL_BITS)
STEP_WIDTH, 24, step counter width (>= 4)
FADE_WIDTH, 21, fade prescaler width
COMMON_ANODE, 1, 1 = active-low outputs
localparam POS_WIDTH = max(1, clog2(CHANNELS))

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
enable  in  1  1 = head advances; 0 = freeze step counter and position
speed  in  3  step rate select; 0 = fastest
direction  in  1  wrap mode: 1 = increment, 0 = decrement
mode  in  1  0 = wrap, 1 = bounce
decay_linear  in  1  0 = level>>1 per fade tick; 1 = saturating level-1
led_out  out  CHANNELS  PWM drive, polarity per COMMON_ANODE
position  out  POS_WIDTH  current head index
step_pulse  out  1  one-cycle pulse on each head step

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following:
  - step_cnt, fade_cnt, pwm_cnt, position, all levels, step_pulse and the input registers.
  - bounce_dir is set to up.
  - Internal lit vector = 0, so led_out = all 1 if COMMON_ANODE, else all 0.
- Input registers: speed, direction, mode and decay_linear are registered once (1-cycle latency) before use.
- Step limit = {speed_q, {STEP_WIDTH-3{1'b1}}}.
- Each cycle with enable=1:
  - If step_cnt >= limit: step_cnt <= 0, step_pulse <= 1, position advances.
  - Otherwise step_cnt++ and step_pulse <= 0.
  - Step period is limit+1 cycles.
  - The >= compare makes a speed decrease mid-count step on the next cycle.
- enable=0: step_cnt, position and bounce_dir hold; step_pulse = 0; fading and PWM continue.
- Wrap mode:
  - direction_q=1: CHANNELS-1 -> 0.
  - direction_q=0: 0 -> CHANNELS-1.
- Bounce mode:
  - Moves per bounce_dir; direction input is ignored.
  - At CHANNELS-1 while up: bounce_dir <= down, next position = CHANNELS-2. Symmetric at 0.
  - Entering bounce mode keeps the current position and bounce_dir.
- CHANNELS=1: position stays 0; step_pulse still fires.
- Position out of range cannot occur; there are no illegal states.
- fade_cnt increments every cycle. Fade tick when fade_cnt == all-ones (wraps to 0). On a fade tick every level decays per decay_linear_q; level 0 stays 0.
- Head refresh: every cycle level[position] <= max. This overrides decay in the same cycle, and the head channel never fades.
- PWM:
  - pwm_cnt increments every cycle.
  - slice = pwm_cnt[PWM_BITS-1 -: LEVEL_BITS].
  - lit[i] registered each cycle = (level[i] != 0) && (level[i] >= slice).
  - Latency from level to led_out is 1 cycle. Level max means always lit; level 0 means always dark.
  - Duty for level L>0 = (L+1)/2^LEVEL_BITS.
- led_out = lit ^ {CHANNELS{COMMON_ANODE}}.
- Reset mid-operation: outputs clear immediately without a clock edge. After release, the first step occurs after limit+1 enabled cycles.

Test Plan:
1. CHANNELS=8, STEP_WIDTH=6, COMMON_ANODE=1; hold reset low, no clk edges -> led_out=8'hFF, position=0, step_pulse=0. Release reset.
2. speed=0, direction=1, mode=0, enable=1 -> step_pulse every 8 cycles; position 0,1,...,7,0. speed=7 -> period 64.
3. Wrap with direction=0 from position 0 -> next 7, then 6. Enable=0 for 20 cycles -> position constant, no step_pulse. Speed change from 7 to 0 with step_cnt=40 -> step 2 cycles later (register + compare).
4. mode=1 starting at position 6, up -> sequence 7,6,5,...,0,1. CHANNELS=1 -> position stays 0, pulses continue.
5. LEVEL_BITS=5, PWM_BITS=5, FADE_WIDTH=4.
   - Head leaves channel 3 with decay_linear=0 -> level[3] follows 31,15,7,3,1,0 on successive 16-cycle fade ticks.
   - decay_linear=1 -> 31,30,29,...
   - Lit counts per 32-cycle window: level 31 -> 32, level 15 -> 16, level 1 -> 2, level 0 -> 0.
6. COMMON_ANODE=0 build with the same stimulus as scenario 5 -> led_out is the bitwise inverse of the COMMON_ANODE=1 trace. Assert reset asynchronously mid-fade -> all levels and led_out clear within the same cycle.
